// File: rtl/xor_arb_pkg.sv
// Shared types and helpers for the round-robin XOR16 arbiter.
// Imported by rr_pick and xor16_rr_arbiter.
package xor_arb_pkg;

    localparam int WORD_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_t;

    // ID width for n requesters, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/student_xor16.sv
// 16-bit XOR from the project-1 gate library.
// Built from AND/OR/NOT gates per bit.
module student_xor16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    logic [15:0] na;
    logic [15:0] nb;
    logic [15:0] t0;
    logic [15:0] t1;

    // Sum-of-products form: a&~b | ~a&b.
    always_comb begin
        na = ~a;
        nb = ~b;
        t0 = a & nb;
        t1 = na & b;
        y  = t0 | t1;
    end

endmodule

// File: rtl/xor16_rr_arbiter_rr_pick.sv
// Round-robin picker: first valid request at or after ptr wins.
// Purely combinational.
module rr_pick
    import xor_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id,
    output logic            found
);

    logic [IDW:0]   slot;
    logic [IDW-1:0] idx;

    // Scan from ptr upward, wrapping modulo NREQ; the first hit wins.
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        slot  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            slot = {1'b0, ptr} + (IDW+1)'(k);
            if (slot >= (IDW+1)'(NREQ)) begin
                slot = slot - (IDW+1)'(NREQ);
            end
            idx = slot[IDW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                id         = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xor16_rr_arbiter.sv
// Round-robin arbiter sharing one student_xor16 among NREQ requesters.
// Optional per-requester grant counters: define XOR16_ARB_STATS_EN.
module xor16_rr_arbiter
    import xor_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WORD_W-1:0] req_a,
    input  logic [NREQ*WORD_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WORD_W-1:0]      rsp_data,
    output logic [IDW-1:0]         rsp_id
`ifdef XOR16_ARB_STATS_EN
    ,
    output logic [NREQ*8-1:0]      grant_cnt
`endif
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [IDW-1:0]    ptr_q;
    logic [NREQ-1:0]   pick;
    logic [IDW-1:0]    win_id;
    logic              any_req;
    logic              can_take;
    logic              grant_en;
    logic [WORD_W-1:0] sel_a;
    logic [WORD_W-1:0] sel_b;
    logic [WORD_W-1:0] xor_y;
    logic [WORD_W-1:0] data_q;
    logic [IDW-1:0]    id_q;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick),
        .id    (win_id),
        .found (any_req)
    );

    // Accept only when the output register is empty or draining;
    // nothing is granted while reset is held.
    always_comb begin
        can_take  = (state_q == IDLE) || rsp_ready;
        grant_en  = rst_n && can_take && any_req;
        req_ready = grant_en ? pick : '0;
        rsp_valid = (state_q == FULL);
    end

    // One-hot AND-OR operand mux into the shared datapath.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_a = sel_a
                  | (req_a[WORD_W*i +: WORD_W] & {WORD_W{pick[i]}});
            sel_b = sel_b
                  | (req_b[WORD_W*i +: WORD_W] & {WORD_W{pick[i]}});
        end
    end

    student_xor16 u_xor (
        .a (sel_a),
        .b (sel_b),
        .y (xor_y)
    );

    // Next state: fill on any request, empty only on drain with no refill.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (rsp_ready && !any_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted result and its ID; hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            id_q   <= '0;
        end else if (grant_en) begin
            data_q <= xor_y;
            id_q   <= win_id;
        end
    end

    // Pointer moves one past the winner, wrapping at NREQ-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (grant_en) begin
            if (win_id == IDW'(NREQ - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= win_id + 1'b1;
            end
        end
    end

    assign rsp_data = data_q;
    assign rsp_id   = id_q;

`ifdef XOR16_ARB_STATS_EN
    logic [7:0] cnt_q [NREQ];

    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_en && pick[i] && cnt_q[i] != 8'hFF) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign grant_cnt[8*g +: 8] = cnt_q[g];
    end
`endif

endmodule
